// File: rtl/ray_march_stepper_if.sv
// rtl/ray_march_stepper_if.sv - request/response link between the ray marcher and the sdf block
interface ray_march_stepper_if #(
    parameter int BITS = 32
);
    logic            sdf_start;
    logic [BITS-1:0] sdf_x;
    logic [BITS-1:0] sdf_y;
    logic [BITS-1:0] sdf_z;
    logic            sdf_done;
    logic [BITS-1:0] sdf_dist;

    // master: the marcher issues sample points and consumes distances
    modport master (
        output sdf_start, sdf_x, sdf_y, sdf_z,
        input  sdf_done, sdf_dist
    );

    // slave: the sdf block evaluates a point and returns its distance
    modport slave (
        input  sdf_start, sdf_x, sdf_y, sdf_z,
        output sdf_done, sdf_dist
    );
endinterface

// File: rtl/ray_march_stepper.sv
// rtl/ray_march_stepper.sv - sphere-tracing controller stepping a Q16.16 ray through an sdf
module ray_march_stepper #(
    parameter int              BITS      = 32,
    parameter int              FIXED     = 16,
    parameter int              MAX_STEPS = 64,
    parameter int              STEP_W    = 8,
    parameter logic [BITS-1:0] EPS       = 32'h0000_0042,
    parameter logic [BITS-1:0] MAX_DIST  = 32'h0010_0000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 march_start,
    input  logic [BITS-1:0]      org_x,
    input  logic [BITS-1:0]      org_y,
    input  logic [BITS-1:0]      org_z,
    input  logic [BITS-1:0]      dir_x,
    input  logic [BITS-1:0]      dir_y,
    input  logic [BITS-1:0]      dir_z,
    ray_march_stepper_if.master  sdf,
    output logic                 march_busy,
    output logic                 march_done,
    output logic                 hit,
    output logic [BITS-1:0]      hit_x,
    output logic [BITS-1:0]      hit_y,
    output logic [BITS-1:0]      hit_z,
    output logic [BITS-1:0]      depth,
    output logic [STEP_W-1:0]    steps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [BITS-1:0]   T_SAT     = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS);

    state_t            state;
    logic [BITS-1:0]   org_x_q, org_y_q, org_z_q;
    logic [BITS-1:0]   dir_x_q, dir_y_q, dir_z_q;
    logic [BITS-1:0]   p_x, p_y, p_z;
    logic [BITS-1:0]   t_q;
    logic [BITS-1:0]   d_q;
    logic [STEP_W-1:0] count_q;
    logic              sdf_start_q;

    logic [BITS:0]     t_sum;
    logic [BITS-1:0]   t_next;
    logic              is_hit;
    logic              is_miss;

    // Offset along one axis: (dir * t) >>> FIXED from a full-width signed product, truncated.
    function automatic logic [BITS-1:0] scale(input logic [BITS-1:0] d, input logic [BITS-1:0] t);
        logic signed [2*BITS-1:0] prod;
        prod = $signed({{BITS{d[BITS-1]}}, d}) * $signed({{BITS{t[BITS-1]}}, t});
        return prod[FIXED +: BITS];
    endfunction

    assign sdf.sdf_start = sdf_start_q;
    assign sdf.sdf_x     = p_x;
    assign sdf.sdf_y     = p_y;
    assign sdf.sdf_z     = p_z;

    // Hit/miss decision and saturating advance of t for the EVAL state.
    always_comb begin
        t_sum   = {t_q[BITS-1], t_q} + {d_q[BITS-1], d_q};
        t_next  = t_sum[BITS-1:0];
        if ($signed(t_sum) > $signed({1'b0, T_SAT})) begin
            t_next = T_SAT;
        end
        is_hit  = $signed(d_q) < $signed(EPS);
        is_miss = ($signed(t_next) > $signed(MAX_DIST)) || (count_q == STEP_LAST);
    end

    // March sequencer; every output is registered on the transition that enters its state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= S_IDLE;
            org_x_q     <= '0;
            org_y_q     <= '0;
            org_z_q     <= '0;
            dir_x_q     <= '0;
            dir_y_q     <= '0;
            dir_z_q     <= '0;
            p_x         <= '0;
            p_y         <= '0;
            p_z         <= '0;
            t_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            sdf_start_q <= 1'b0;
            march_busy  <= 1'b0;
            march_done  <= 1'b0;
            hit         <= 1'b0;
            hit_x       <= '0;
            hit_y       <= '0;
            hit_z       <= '0;
            depth       <= '0;
            steps       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (march_start) begin
                        org_x_q     <= org_x;
                        org_y_q     <= org_y;
                        org_z_q     <= org_z;
                        dir_x_q     <= dir_x;
                        dir_y_q     <= dir_y;
                        dir_z_q     <= dir_z;
                        p_x         <= org_x;
                        p_y         <= org_y;
                        p_z         <= org_z;
                        t_q         <= '0;
                        count_q     <= '0;
                        sdf_start_q <= 1'b1;
                        march_busy  <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sdf_start_q <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (sdf.sdf_done) begin
                        d_q     <= sdf.sdf_dist;
                        count_q <= count_q + 1'b1;
                        state   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (is_hit) begin
                        hit        <= 1'b1;
                        hit_x      <= p_x;
                        hit_y      <= p_y;
                        hit_z      <= p_z;
                        depth      <= t_q;
                        steps      <= count_q;
                        march_done <= 1'b1;
                        state      <= S_DONE;
                    end else if (is_miss) begin
                        t_q        <= t_next;
                        hit        <= 1'b0;
                        hit_x      <= p_x;
                        hit_y      <= p_y;
                        hit_z      <= p_z;
                        depth      <= t_next;
                        steps      <= count_q;
                        march_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        t_q   <= t_next;
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    p_x         <= org_x_q + scale(dir_x_q, t_q);
                    p_y         <= org_y_q + scale(dir_y_q, t_q);
                    p_z         <= org_z_q + scale(dir_z_q, t_q);
                    sdf_start_q <= 1'b1;
                    state       <= S_ISSUE;
                end
                S_DONE: begin
                    march_done <= 1'b0;
                    march_busy <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_march_stepper.sv
// tb/tb_ray_march_stepper.sv - directed scoreboard bench for ray_march_stepper
module tb_ray_march_stepper;

    localparam int BITS = 32;

    typedef struct {
        logic        h;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] d;
        logic [7:0]  s;
        int          lat;
    } res_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        march_start = 1'b0;
    logic [31:0] org_x = '0, org_y = '0, org_z = '0;
    logic [31:0] dir_x = '0, dir_y = '0, dir_z = '0;
    logic        march_busy, march_done, hit;
    logic [31:0] hit_x, hit_y, hit_z, depth;
    logic [7:0]  steps;

    ray_march_stepper_if #(.BITS(BITS)) sdf_bus ();

    ray_march_stepper dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .march_start (march_start),
        .org_x       (org_x),
        .org_y       (org_y),
        .org_z       (org_z),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .dir_z       (dir_z),
        .sdf         (sdf_bus),
        .march_busy  (march_busy),
        .march_done  (march_done),
        .hit         (hit),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .hit_z       (hit_z),
        .depth       (depth),
        .steps       (steps)
    );

    always #5 clk_in = ~clk_in;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // sdf stub: answers each request stub_lat falling edges later
    int          stub_mode = 0;
    int          stub_lat = 1;
    int          stub_cnt = 0;
    int          stub_idx = 0;
    int          spur_cnt = 0;
    bit          stub_spurious = 1'b0;
    logic [31:0] stub_px = '0;

    function automatic logic [31:0] stub_dist(input int mode, input logic [31:0] x);
        case (mode)
            1:       return 32'h0001_0000;
            2:       return 32'h0000_0100;
            3:       return 32'h0005_0000 - x;
            4:       return 32'hFFFF_8000;
            5:       return 32'h0001_8000;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk_in) begin
        sdf_bus.sdf_done = 1'b0;
        if (spur_cnt > 0) begin
            spur_cnt--;
            if (spur_cnt == 0) begin
                sdf_bus.sdf_done = 1'b1;
                sdf_bus.sdf_dist = 32'h0;
            end
        end
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                sdf_bus.sdf_done = 1'b1;
                sdf_bus.sdf_dist = stub_dist(stub_mode, stub_px);
                if (stub_spurious) spur_cnt = 2;
            end
        end
        if (sdf_bus.sdf_start === 1'b1) begin
            check("sdf_start_outstanding", 64'(stub_cnt), 64'd0);
            if (stub_mode == 1) begin
                check("sdf_x_seq", 64'(sdf_bus.sdf_x), 64'(stub_idx * 32'h1_0000));
                stub_idx++;
            end
            stub_px  = sdf_bus.sdf_x;
            stub_cnt = stub_lat;
        end
    end

    task automatic run_ray(input logic [31:0] ox, oy, oz, dx, dy, dz,
                           input int mode, input res_t exp, input bit intrude);
        res_t e;
        int   n;
        stub_mode = mode;
        stub_idx  = 0;
        sb.push_back(exp);
        @(negedge clk_in);
        org_x = ox; org_y = oy; org_z = oz;
        dir_x = dx; dir_y = dy; dir_z = dz;
        march_start = 1'b1;
        @(negedge clk_in);
        march_start = 1'b0;
        check("issue_after_start", {sdf_bus.sdf_start, march_busy}, 2'b11);
        n = 0;
        if (intrude) begin
            repeat (5) @(negedge clk_in);
            n += 5;
            org_x = 32'h7000_0000; dir_y = 32'h0001_0000;
            march_start = 1'b1;
            @(negedge clk_in);
            n++;
            march_start = 1'b0;
        end
        while (march_done !== 1'b1 && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        check("done_seen", 64'(march_done), 64'd1);
        e = sb.pop_front();
        if (march_done === 1'b1) begin
            check("latency", 64'(n), 64'(e.lat));
            check("hit", 64'(hit), 64'(e.h));
            check("hit_xy", {hit_x, hit_y}, {e.x, e.y});
            check("hit_z", 64'(hit_z), 64'(e.z));
            check("depth_steps", {24'h0, steps, depth}, {24'h0, e.s, e.d});
        end
        @(negedge clk_in);
        check("idle_after_done", {march_busy, march_done}, 2'b00);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        #1 rst_in = 1'b0;
        #1;
        check("reset_ctrl", {sdf_bus.sdf_start, march_busy, march_done, hit, steps}, 64'd0);
        check("reset_sdf_xy", {sdf_bus.sdf_x, sdf_bus.sdf_y}, 64'd0);
        check("reset_depth_hz", {depth, hit_z}, 64'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;

        // immediate hit on zero distance
        run_ray(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h1_0000, 0, 0, 0,
                '{1'b1, 32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h0, 8'd1, 3}, 1'b0);
        // unit steps along +x until past the far plane
        run_ray(0, 0, 0, 32'h1_0000, 0, 0, 1,
                '{1'b0, 32'h10_0000, 32'h0, 32'h0, 32'h11_0000, 8'd17, 67}, 1'b0);
        // tiny steps along +y exhaust the step budget
        run_ray(0, 0, 0, 0, 32'h1_0000, 0, 2,
                '{1'b0, 32'h0, 32'h3F00, 32'h0, 32'h4000, 8'd64, 255}, 1'b0);
        // plane at x = 5.0
        run_ray(0, 0, 0, 32'h1_0000, 0, 0, 3,
                '{1'b1, 32'h5_0000, 32'h0, 32'h0, 32'h5_0000, 8'd2, 7}, 1'b0);
        // negative distance on the first query counts as a hit
        run_ray(32'h8000, 32'hFFFF_0000, 32'h7_0000, 0, 32'h1_0000, 0, 4,
                '{1'b1, 32'h8000, 32'hFFFF_0000, 32'h7_0000, 32'h0, 8'd1, 3}, 1'b0);
        // 1.5 steps along -z, fractional depth and negative product
        run_ray(32'h2_0000, 0, 0, 0, 0, 32'hFFFF_0000, 5,
                '{1'b0, 32'h2_0000, 32'h0, 32'hFFF1_0000, 32'h10_8000, 8'd11, 43}, 1'b0);
        // restart and spurious completions while busy must not disturb the march
        stub_spurious = 1'b1;
        run_ray(0, 0, 0, 32'h1_0000, 0, 0, 1,
                '{1'b0, 32'h10_0000, 32'h0, 32'h0, 32'h11_0000, 8'd17, 67}, 1'b1);
        stub_spurious = 1'b0;
        repeat (4) @(negedge clk_in);

        // reset while waiting on the sdf
        stub_mode = 2;
        stub_lat  = 5;
        @(negedge clk_in);
        org_x = 32'h1_0000; org_y = 32'h2_0000; org_z = 32'h3_0000;
        dir_x = 32'h1_0000; dir_y = 0; dir_z = 0;
        march_start = 1'b1;
        @(negedge clk_in);
        march_start = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("midrst_ctrl", {sdf_bus.sdf_start, march_busy, march_done, hit, steps}, 64'd0);
        check("midrst_sdf_xy", {sdf_bus.sdf_x, sdf_bus.sdf_y}, 64'd0);
        check("midrst_sdf_z_depth", {sdf_bus.sdf_z, depth}, 64'd0);
        check("midrst_hit_xy", {hit_x, hit_y}, 64'd0);
        check("midrst_hit_z", 64'(hit_z), 64'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (march_done !== 1'b0 || march_busy !== 1'b0) seen = 1'b1;
        end
        check("no_done_after_abort", 64'(seen), 64'd0);
        stub_lat = 1;

        run_ray(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h1_0000, 0, 0, 0,
                '{1'b1, 32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h0, 8'd1, 3}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
